// File: rtl/audio_stream_out.sv
`default_nettype none
// ==========================================================================
// audio_stream_out : divides clk into a sample tick, buffers scaled PCM in
// a small FIFO and presents each sample to both codec channels.
// Rev 1.0
// ==========================================================================
module audio_stream_out #(
  parameter int SAMPLE_DIV = 1042,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        mute,
  input  logic [2:0]  volume,
  output logic [15:0] left_data,
  output logic [15:0] right_data,
  output logic        left_valid,
  output logic        right_valid,
  input  logic        left_ready,
  input  logic        right_ready,
  output logic [7:0]  overflow_cnt,
  output logic        fifo_empty
);

  localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW        = 16;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   left_data_q, left_data_d, right_data_q, right_data_d;
  logic          left_valid_q, left_valid_d, right_valid_q, right_valid_d;
  logic [7:0]    ovf_q, ovf_d;

  logic          tick, full, pop, push;
  logic signed [15:0] scaled;
  logic [15:0]   captured;

  assign scaled   = $signed(sample_in) >>> volume;
  assign captured = mute ? 16'h0000 : scaled;

  // A pop in the same cycle frees the slot a full-FIFO tick needs.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    full       = (count_q == FULL_CNT);
    pop        = (state_q == IDLE) && (count_q != '0);
    push       = tick && (!full || pop);
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d      = ovf_q;
    if (tick && full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    left_data_d   = left_data_q;
    right_data_d  = right_data_q;
    left_valid_d  = left_valid_q;
    right_valid_d = right_valid_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          left_data_d   = mem_q[rd_ptr_q];
          right_data_d  = mem_q[rd_ptr_q];
          left_valid_d  = 1'b1;
          right_valid_d = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        left_valid_d  = left_valid_q & ~left_ready;
        right_valid_d = right_valid_q & ~right_ready;
        if (!left_valid_d && !right_valid_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      left_data_q   <= '0;
      right_data_q  <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      wr_ptr_q      <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q      <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q       <= count_d;
      left_data_q   <= left_data_d;
      right_data_q  <= right_data_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= captured;
    end
  end

  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign left_valid   = left_valid_q;
  assign right_valid  = right_valid_q;
  assign overflow_cnt = ovf_q;
  assign fifo_empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_out.sv
`default_nettype none
// tb_audio_stream_out : table vectors, corner sequences and random traffic
// checked against a queue-level model of the sample path.
module tb_audio_stream_out;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        mute;
  logic [2:0]  volume;
  logic [15:0] left_data, right_data;
  logic        left_valid, right_valid;
  logic        left_ready, right_ready;
  logic [7:0]  overflow_cnt;
  logic        fifo_empty;

  audio_stream_out #(.SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .mute         (mute),
    .volume       (volume),
    .left_data    (left_data),
    .right_data   (right_data),
    .left_valid   (left_valid),
    .right_valid  (right_valid),
    .left_ready   (left_ready),
    .right_ready  (right_ready),
    .overflow_cnt (overflow_cnt),
    .fifo_empty   (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pending samples as a queue, plus the word currently offered.
  int          m_cyc;
  logic [15:0] m_q[$];
  logic        m_lv, m_rv;
  logic [15:0] m_word;
  int          m_ovf;

  typedef struct {
    logic [15:0] smp;
    logic [2:0]  vol;
    logic        mu;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic right shift expressed as floor division by 2**v.
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [2:0] v, input logic m);
    int val, d, q;
    val = int'($signed(s));
    d   = 1 << v;
    q   = val / d;
    if ((val % d) != 0 && val < 0) q = q - 1;
    return m ? 16'h0000 : q[15:0];
  endfunction

  task automatic model_reset();
    m_cyc  = 0;
    m_q.delete();
    m_lv   = 1'b0;
    m_rv   = 1'b0;
    m_word = 16'h0000;
    m_ovf  = 0;
  endtask

  task automatic step();
    logic        popping;
    logic [15:0] s;
    popping = !(m_lv || m_rv) && (m_q.size() > 0);
    s = scale(sample_in, volume, mute);
    if ((m_cyc % DIV) == DIV - 1) begin
      if (m_q.size() < DEPTH || popping) m_q.push_back(s);
      else if (m_ovf < 255) m_ovf++;
    end
    if (popping) begin
      m_word = m_q.pop_front();
      m_lv   = 1'b1;
      m_rv   = 1'b1;
    end else begin
      if (m_lv && left_ready)  m_lv = 1'b0;
      if (m_rv && right_ready) m_rv = 1'b0;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    chk("left_valid",   left_valid,   m_lv);
    chk("right_valid",  right_valid,  m_rv);
    chk("left_data",    left_data,    m_word);
    chk("right_data",   right_data,   m_word);
    chk("overflow_cnt", overflow_cnt, m_ovf);
    chk("fifo_empty",   fifo_empty,   (m_q.size() == 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_left_valid",  left_valid,   1'b0);
    chk("rst_right_valid", right_valid,  1'b0);
    chk("rst_data",        left_data,    16'h0000);
    chk("rst_ovf",         overflow_cnt, 8'h00);
    chk("rst_empty",       fifo_empty,   1'b1);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] got[$];
    logic [15:0] exp_w;
    int          p;

    reset = 1'b1; sample_in = 16'h0000; mute = 1'b0; volume = 3'd0;
    left_ready = 1'b0; right_ready = 1'b0;
    model_reset();

    vecs[0] = '{16'h7FFF, 3'd0, 1'b0, 16'h7FFF};
    vecs[1] = '{16'h8000, 3'd3, 1'b0, 16'hF000};
    vecs[2] = '{16'h8000, 3'd3, 1'b1, 16'h0000};
    vecs[3] = '{16'h0040, 3'd7, 1'b0, 16'h0000};
    vecs[4] = '{16'hFFFF, 3'd1, 1'b0, 16'hFFFF};
    vecs[5] = '{16'h1234, 3'd4, 1'b0, 16'h0123};
    vecs[6] = '{16'h8000, 3'd7, 1'b0, 16'hFF00};
    vecs[7] = '{16'h7FFF, 3'd7, 1'b0, 16'h00FF};

    // Tick at edge DIV-1, word visible after edge DIV, accepted at DIV+1.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      sample_in = vecs[i].smp; volume = vecs[i].vol; mute = vecs[i].mu;
      left_ready = 1'b1; right_ready = 1'b1;
      repeat (DIV) step();
      chk($sformatf("vec%0d_not_yet", i), left_valid, 1'b0);
      step();
      chk($sformatf("vec%0d_valid", i), {left_valid, right_valid}, 2'b11);
      chk($sformatf("vec%0d_ldata", i), left_data,  vecs[i].exp);
      chk($sformatf("vec%0d_rdata", i), right_data, vecs[i].exp);
      step();
      chk($sformatf("vec%0d_cleared", i), {left_valid, right_valid}, 2'b00);
    end

    // Skewed handshake: right held off for five cycles.
    do_reset();
    sample_in = 16'h1234; volume = 3'd0; mute = 1'b0;
    left_ready = 1'b1; right_ready = 1'b0;
    repeat (DIV + 1) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("skew_left_low",   left_valid,  1'b0);
      chk("skew_right_hold", right_valid, 1'b1);
      chk("skew_right_data", right_data,  16'h1234);
    end
    right_ready = 1'b1;
    step();
    chk("skew_right_done", right_valid, 1'b0);
    chk("skew_single_pop", fifo_empty,  1'b1);

    // Overflow: stall, saturate the counter, then drain in capture order.
    do_reset();
    left_ready = 1'b0; right_ready = 1'b0;
    for (int c = 0; c < DIV * 310; c++) begin
      sample_in = 16'(c * 7 + 1);
      step();
    end
    chk("ovf_saturated", overflow_cnt, 8'hFF);
    sample_in = 16'hABCD;
    left_ready = 1'b1; right_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 5; c++) begin
      if (left_valid) got.push_back(left_data);
      step();
    end
    chk("drain_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      exp_w = 16'((8 * k + 7) * 7 + 1);
      chk($sformatf("drain_word%0d", k), got[k], exp_w);
    end

    // Full FIFO: the tick that meets an IDLE pop must be kept.
    do_reset();
    left_ready = 1'b0; right_ready = 1'b0; sample_in = 16'h0101;
    repeat (46) step();
    chk("fp_full_ovf", overflow_cnt, 8'h00);
    left_ready = 1'b1; right_ready = 1'b1;
    step();
    left_ready = 1'b0; right_ready = 1'b0;
    step();
    chk("fp_no_drop", overflow_cnt, 8'h00);
    chk("fp_loaded",  left_valid,   1'b1);
    repeat (DIV) step();
    chk("fp_next_drop", overflow_cnt, 8'h01);

    // Asynchronous reset in the middle of a SEND.
    do_reset();
    sample_in = 16'h5555;
    repeat (DIV + 1) step();
    chk("ar_in_send", left_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_left_drop",  left_valid,   1'b0);
    chk("ar_right_drop", right_valid,  1'b0);
    chk("ar_empty",      fifo_empty,   1'b1);
    chk("ar_ovf",        overflow_cnt, 8'h00);
    #2;
    reset = 1'b0;
    model_reset();
    left_ready = 1'b1; right_ready = 1'b1;
    repeat (DIV) step();
    chk("ar_no_early_word", left_valid, 1'b0);
    step();
    chk("ar_first_word", left_valid, 1'b1);

    // Random traffic with phases of differing backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case (c / 500)
        0: p = 90;
        1: p = 10;
        2: p = 50;
        3: p = 100;
        4: p = 0;
        default: p = 30;
      endcase
      sample_in   = 16'($urandom);
      volume      = 3'($urandom_range(0, 7));
      mute        = ($urandom_range(0, 9) == 0);
      left_ready  = ($urandom_range(0, 99) < p);
      right_ready = ($urandom_range(0, 99) < p);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_stream_out.md
AUDIO_STREAM_OUT -- requirements
Module: audio_stream_out

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1042, meaning clk cycles per output sample (50 MHz / 1042 ≈ 48 kHz); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sample_in, input, 16 bits: signed PCM from the tone generator, free-running.
REQ-006 SHALL have port mute, input, 1 bit: when high, captured samples become 0.
REQ-007 SHALL have port volume, input, 3 bits: attenuation as an arithmetic right shift of 0..7.
REQ-008 SHALL have ports left_data and right_data, output, 16 bits each: signed sample to the codec.
REQ-009 SHALL have ports left_valid and right_valid, output, 1 bit each: channel word valid.
REQ-010 SHALL have ports left_ready and right_ready, input, 1 bit each: codec accepts the channel word.
REQ-011 SHALL have port overflow_cnt, output, 8 bits: count of dropped samples, saturating.
REQ-012 SHALL have port fifo_empty, output, 1 bit: FIFO holds no entries.

Function
REQ-013 SHALL run a tick counter 0..SAMPLE_DIV-1 that wraps to 0, with tick high in the cycle the counter equals SAMPLE_DIV-1.
REQ-014 SHALL produce the first tick in cycle SAMPLE_DIV-1 after reset deassertion, where cycle 0 is the first rising edge.
REQ-015 SHALL on tick capture sample_in, apply ">>> volume" (sign-preserving), force 0 if mute, then write the result into the FIFO at that edge.
REQ-016 SHALL keep the FIFO full condition based on pre-edge occupancy, except that a tick coinciding with a pop while full is accepted: one entry out, one in.
REQ-017 SHALL drop a tick's sample when the FIFO is full and no pop occurs that cycle; overflow_cnt increments by 1 and saturates at 255.
REQ-018 SHALL implement an output FSM with states IDLE and SEND.
REQ-019 SHALL in IDLE with the FIFO non-empty pop the head, load it into both left_data and right_data, set both valids, and go to SEND.
REQ-020 SHALL in SEND clear each valid on the edge where that channel's valid&ready is high, independently per channel.
REQ-021 SHALL hold data stable while the respective valid is high.
REQ-022 SHALL leave SEND for IDLE once both channels have been accepted (same or different cycles); no new word is loaded in that cycle.
REQ-023 SHALL give a latency of 2 cycles from tick to valids when idle and empty: written at edge t, popped and loaded at edge t+1, valid observable after edge t+1.
REQ-024 SHALL ignore ready inputs while the corresponding valid is low.
REQ-025 SHALL keep data outputs holding their last value in IDLE; fifo_empty is combinational from occupancy.
REQ-026 SHALL never drop or duplicate a FIFO entry under backpressure; the FIFO is wrap-around indexed with an occupancy count of 0..FIFO_DEPTH.

Reset
REQ-027 SHALL while reset is high asynchronously clear the tick counter, FIFO pointers and occupancy, FSM state (to IDLE), left_data, right_data, both valids, and overflow_cnt, with fifo_empty=1.
REQ-028 SHALL on reset mid-SEND drop valids immediately without waiting for the clock, and discard the word in flight and FIFO contents.
REQ-029 SHALL resume the tick count from 0 after deassertion.

Verification
REQ-030 Test basic: SAMPLE_DIV=8, sample_in=16'sh7FFF, volume=0, readies=1 -> first tick at cycle 7; both valids high one cycle after edge 8 with data 7FFF; valids clear next edge; FSM returns to IDLE.
REQ-031 Test scaling: sample_in=16'sh8000, volume=3 -> data F000; mute=1 -> data 0000; volume=7 with sample_in=16'sh0040 -> 0000.
REQ-032 Test skewed handshake: left_ready=1, right_ready held low 5 cycles -> left_valid clears after 1 accept; right_valid and right_data hold stable 5 cycles; one pop only; IDLE after right accept.
REQ-033 Test overflow: readies=0, FIFO_DEPTH=4, SAMPLE_DIV=8 -> 1 word loaded to output plus 4 in FIFO; 6th and later ticks drop and overflow_cnt counts; after 300 drops it stays 255; releasing readies drains 5 words in capture order.
REQ-034 Test full plus pop: FIFO full, tick in same cycle as IDLE pop -> occupancy stays 4, overflow_cnt unchanged.
REQ-035 Test async reset: assert reset mid-SEND between edges -> valids low before the next edge; after release, fifo_empty=1, overflow_cnt=0, first tick at cycle SAMPLE_DIV-1.
